min_pool: RTL and testbench

MIN_POOL -- requirements
Module: min_pool

---
 rtl/min_pool.sv | 149 ++++++++++++++
 tb/tb_min_pool.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/min_pool.sv
// Streaming FP32 min-pooling over windows of WINDOW elements with early flush.
// Optional MIN_POOL_NAN_EN: a window containing any NaN yields the canonical quiet NaN.
module min_pool #(
   parameter int WINDOW = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [7:0]  out_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [7:0] WIN_LAST = 8'(WINDOW);

   state_t      state, state_next;
   logic [31:0] acc, acc_next;
   logic [7:0]  count, count_next;
   logic        accept;

   // Strict FP32 ordering on raw bits; +0 and -0 are equal.
   function automatic logic fp_less(input logic [31:0] a, input logic [31:0] b);
      logic res;
      if (a[31] != b[31]) begin
         if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
            res = 1'b0;
         end else begin
            res = a[31];
         end
      end else if (a[31] == 1'b0) begin
         res = (a[30:0] < b[30:0]);
      end else begin
         res = (a[30:0] > b[30:0]);
      end
      return res;
   endfunction

`ifdef MIN_POOL_NAN_EN
   logic nan_flag, nan_next;

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction
`endif

   assign accept    = in_valid && in_ready;
   assign in_ready  = rst_n && (state != HOLD);
   assign out_valid = (state == HOLD);
   assign out_count = (state == HOLD) ? count : 8'd0;
`ifdef MIN_POOL_NAN_EN
   assign out_data  = (state != HOLD) ? 32'd0 : (nan_flag ? 32'h7FC00000 : acc);
`else
   assign out_data  = (state == HOLD) ? acc : 32'd0;
`endif

   // Next-state, accumulator and count update.
   always_comb begin
      state_next = state;
      acc_next   = acc;
      count_next = count;
`ifdef MIN_POOL_NAN_EN
      nan_next   = nan_flag;
`endif
      case (state)
         IDLE: begin
            if (accept) begin
               acc_next   = in_data;
               count_next = 8'd1;
`ifdef MIN_POOL_NAN_EN
               nan_next   = is_nan(in_data);
`endif
               if ((count_next == WIN_LAST) || flush) begin
                  state_next = HOLD;
               end else begin
                  state_next = ACCUM;
               end
            end else begin
               state_next = IDLE;
            end
         end
         ACCUM: begin
            if (accept) begin
               if (fp_less(in_data, acc)) begin
                  acc_next = in_data;
               end else begin
                  acc_next = acc;
               end
               count_next = count + 8'd1;
`ifdef MIN_POOL_NAN_EN
               nan_next   = nan_flag | is_nan(in_data);
`endif
            end else begin
               count_next = count;
            end
            // A flush with nothing new still closes the non-empty partial window.
            if ((accept && (count_next == WIN_LAST)) || flush) begin
               state_next = HOLD;
            end else begin
               state_next = ACCUM;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = IDLE;
               count_next = 8'd0;
`ifdef MIN_POOL_NAN_EN
               nan_next   = 1'b0;
`endif
            end else begin
               state_next = HOLD;
            end
         end
         default: begin
            state_next = IDLE;
            count_next = 8'd0;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         acc   <= 32'd0;
         count <= 8'd0;
`ifdef MIN_POOL_NAN_EN
         nan_flag <= 1'b0;
`endif
      end else begin
         state <= state_next;
         acc   <= acc_next;
         count <= count_next;
`ifdef MIN_POOL_NAN_EN
         nan_flag <= nan_next;
`endif
      end
   end

endmodule

// File: tb/tb_min_pool.sv
// Self-checking bench for min_pool: directed scenarios plus randomized traffic
// compared cycle by cycle against a window-queue reference model.
module tb_min_pool;

   localparam int W = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'd0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [7:0]  out_count;

   int checks = 0;
   int errors = 0;

   // Reference model state: elements of the open window and any pending result.
   logic [31:0] win[$];
   logic        pending = 1'b0;
   logic [31:0] pend_data = 32'd0;
   logic [7:0]  pend_count = 8'd0;

   min_pool #(.WINDOW(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Numeric value of an FP32 pattern as a signed magnitude; both zeros map to 0.
   function automatic longint fp_key(input logic [31:0] x);
      longint m;
      m = longint'(x[30:0]);
      return x[31] ? -m : m;
   endfunction

   function automatic logic [31:0] ref_min();
      logic [31:0] best;
      best = win[0];
      foreach (win[i]) begin
         if (fp_key(win[i]) < fp_key(best)) best = win[i];
      end
`ifdef MIN_POOL_NAN_EN
      foreach (win[i]) begin
         if ((win[i][30:23] == 8'hFF) && (win[i][22:0] != 23'd0)) best = 32'h7FC00000;
      end
`endif
      return best;
   endfunction

   // One clock: apply inputs, advance model at the edge, compare outputs after it.
   task automatic cycle(input logic rst, input logic v, input logic [31:0] d,
                        input logic f, input logic r);
      logic acc;
      rst_n = rst; in_valid = v; in_data = d; flush = f; out_ready = r;
      acc = v && rst && !pending;
      @(posedge clk);
      #1;
      if (!rst) begin
         win.delete();
         pending = 1'b0;
      end else if (pending) begin
         if (r) pending = 1'b0;
      end else begin
         if (acc) win.push_back(d);
         if ((win.size() == W) || (f && (win.size() > 0))) begin
            pend_data  = ref_min();
            pend_count = 8'(win.size());
            pending    = 1'b1;
            win.delete();
         end
      end
      check("in_ready",  {31'd0, in_ready},  {31'd0, rst && !pending});
      check("out_valid", {31'd0, out_valid}, {31'd0, pending});
      check("out_data",  out_data, pending ? pend_data : 32'd0);
      check("out_count", {24'd0, out_count}, {24'd0, pending ? pend_count : 8'd0});
   endtask

   function automatic logic [31:0] rand_elem();
      logic [31:0] pool[8];
      pool = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
               32'h40000000, 32'hC0000000, 32'h7F800001, 32'h3F800000};
      if ($urandom_range(0, 2) == 0) return $urandom();
      return pool[$urandom_range(0, 7)];
   endfunction

   initial begin
      logic [31:0] held;
      cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 32'h3F800000, 1'b0, 1'b0);
      check("reset_data", out_data, 32'd0);

      // Mixed signs; result visible right after the 4th acceptance.
      cycle(1'b1, 1'b1, 32'h3F800000, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'hC0000000, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'h40000000, 1'b0, 1'b0);
      check("pre_last_valid", {31'd0, out_valid}, 32'd0);
      cycle(1'b1, 1'b1, 32'hBF800000, 1'b0, 1'b0);
      check("mixed_min", out_data, 32'hC0000000);
      check("mixed_count", {24'd0, out_count}, 32'd4);
      held = out_data;
      // Backpressure for 5 cycles while input and flush keep arriving.
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 1'b1, 32'hFF000000, 1'b1, 1'b0);
         check("hold_stable", out_data, held);
      end
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      check("consumed_idle", {31'd0, out_valid}, 32'd0);

      // Zero tie: +0 first wins over -0.
      cycle(1'b1, 1'b1, 32'h00000000, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'h80000000, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'h3F800000, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'h40000000, 1'b0, 1'b0);
      check("zero_tie", out_data, 32'h00000000);
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);

      // Early flush of a two-element window; lone flush in IDLE ignored.
      cycle(1'b1, 1'b1, 32'h40000000, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'h3F800000, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
      check("flush_min", out_data, 32'h3F800000);
      check("flush_count", {24'd0, out_count}, 32'd2);
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
      check("idle_flush_none", {31'd0, out_valid}, 32'd0);

      // Flush together with the first acceptance closes a 1-element window.
      cycle(1'b1, 1'b1, 32'hC0000000, 1'b1, 1'b0);
      check("idle_flush_count", {24'd0, out_count}, 32'd1);
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);

      // Reset mid-window discards it; next window starts fresh.
      cycle(1'b1, 1'b1, 32'hC0000000, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'hC0000000, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
      check("mid_reset_ready", {31'd0, in_ready}, 32'd0);
      cycle(1'b1, 1'b1, 32'h40000000, 1'b1, 1'b0);
      check("fresh_count", {24'd0, out_count}, 32'd1);
      check("fresh_data", out_data, 32'h40000000);
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);

      // NaN pattern handling depends on the build.
      cycle(1'b1, 1'b1, 32'h3F800000, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'h7F800001, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'hBF800000, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 32'h40000000, 1'b0, 1'b0);
`ifdef MIN_POOL_NAN_EN
      check("nan_result", out_data, 32'h7FC00000);
`else
      check("nan_result", out_data, 32'hBF800000);
`endif
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b1);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 9) < 7),
               rand_elem(),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 9) < 6));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
